// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: |a - b| one decimal digit per clock, LSD first,
// with a separate sign flag and a non-BCD input flag. Start/done handshake.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    NEG,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_diff;
  logic                r_neg;
  logic                r_err;
  logic                r_borrow;
  logic [IW-1:0]       r_idx;

  logic                w_inErr;
  logic                w_lastDigit;
  logic [3:0]          w_minDig;
  logic [3:0]          w_subDig;
  logic [4:0]          w_t;
  logic                w_borrowOut;
  logic [3:0]          w_resDig;

  always_comb begin
    w_inErr = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        w_inErr = 1'b1;
      end
    end
  end

  // One digit slice shared by both passes: SUB does a_i - b_i, NEG does 0 - r_i.
  always_comb begin
    w_lastDigit = (r_idx == LAST_IDX);
    w_minDig    = (r_state == SUB) ? r_a[r_idx*4 +: 4] : 4'd0;
    w_subDig    = (r_state == SUB) ? r_b[r_idx*4 +: 4] : r_diff[r_idx*4 +: 4];
    w_t         = {1'b0, w_minDig} - {1'b0, w_subDig} - {4'd0, r_borrow};
    w_borrowOut = w_t[4];
    w_resDig    = w_borrowOut ? (w_t[3:0] + 4'd10) : w_t[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = w_inErr ? DONE : SUB;
        end
      end
      SUB: begin
        busy = 1'b1;
        if (w_lastDigit) begin
          w_nextState = w_borrowOut ? NEG : DONE;
        end
      end
      NEG: begin
        busy = 1'b1;
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_neg    <= 1'b0;
            r_err    <= w_inErr;
            r_borrow <= 1'b0;
            r_idx    <= '0;
          end
        end
        SUB, NEG: begin
          r_diff[r_idx*4 +: 4] <= w_resDig;
          if (w_lastDigit) begin
            r_idx    <= '0;
            r_borrow <= 1'b0;
            if (r_state == NEG) begin
              r_neg <= 1'b1;
            end
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_borrow <= w_borrowOut;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = r_diff;
  assign neg  = r_neg;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed bench for bcd_sub_serial: table of hand-computed vectors plus
// sequences for ignored restart and reset during the NEG pass.
module tb_bcd_sub_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] diff;
  logic        neg;
  logic        err;
  logic        busy;
  logic        done;

  int passCount;
  int checkCount;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expDiff;
    logic        expNeg;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  bcd_sub_serial #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .neg   (neg),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Latency counts cycles after the accept edge; cycle 1 is the one right after it.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               output int lat, output int overlap);
    int c;
    a       = av;
    b       = bv;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    overlap = 0;
    c       = 1;
    while (!done && c < 40) begin
      if (done && busy) overlap = 1;
      @(posedge clk);
      #1;
      c++;
    end
    if (done) begin
      lat = c;
      if (busy) overlap = 1;
    end
  endtask

  initial begin
    int lat;
    int overlap;
    int extra;
    int c;

    passCount  = 0;
    checkCount = 0;

    vecs[0] = '{16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, 5};
    vecs[1] = '{16'h1234, 16'h5321, 16'h4087, 1'b1, 1'b0, 9};
    vecs[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
    vecs[3] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5};
    vecs[4] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[5] = '{16'h0010, 16'h0001, 16'h0009, 1'b0, 1'b0, 5};
    vecs[6] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5};
    vecs[7] = '{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 9};
    vecs[8] = '{16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[9] = '{16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 5};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_diff", diff, 16'h0000);
    checkOutput("reset_neg", neg, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vectors run back to back: each starts on the cycle after the previous done.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat, overlap);
      $display("[TB] vector %0d: %h - %h", i, vecs[i].a, vecs[i].b);
      checkOutput("latency", lat, vecs[i].expLat);
      checkOutput("diff", diff, vecs[i].expDiff);
      checkOutput("neg", neg, vecs[i].expNeg);
      checkOutput("err", err, vecs[i].expErr);
      checkOutput("busy_done_overlap", overlap, 0);
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", done, 0);
      checkOutput("hold_diff", diff, vecs[i].expDiff);
    end

    // Start re-asserted at cycle 2 of an operation must be ignored.
    a     = 16'h5321;
    b     = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a     = 16'h1111;
    b     = 16'h2222;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c     = 3;
    while (!done && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    lat = done ? c : 0;
    checkOutput("restart_latency", lat, 5);
    checkOutput("restart_diff", diff, 16'h4087);
    checkOutput("restart_neg", neg, 0);
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checkOutput("restart_no_second_done", extra, 0);
    checkOutput("restart_diff_held", diff, 16'h4087);

    // Reset while in the NEG pass of 1234 - 5321 (NEG spans cycles 5..8).
    a     = 16'h1234;
    b     = 16'h5321;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("neg_phase_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_diff", diff, 16'h0000);
    checkOutput("abort_neg", neg, 0);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    checkOutput("abort_stays_idle", extra, 0);

    applyStimulus(16'h0100, 16'h0001, lat, overlap);
    checkOutput("post_reset_latency", lat, 5);
    checkOutput("post_reset_diff", diff, 16'h0099);
    checkOutput("post_reset_neg", neg, 0);
    checkOutput("post_reset_err", err, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
